// File: rtl/bridge_pkg.sv
// Shared FSM encoding, default slave windows and the timeout-counter width helper
// for the CPU-to-slave system bridge.
package bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Default DM / TC0 / TC1 inclusive windows.
    localparam logic [31:0] DM_LO  = 32'h0000_0000;
    localparam logic [31:0] DM_HI  = 32'h0000_2FFF;
    localparam logic [31:0] TC0_LO = 32'h0000_7F00;
    localparam logic [31:0] TC0_HI = 32'h0000_7F0B;
    localparam logic [31:0] TC1_LO = 32'h0000_7F10;
    localparam logic [31:0] TC1_HI = 32'h0000_7F1B;

    localparam logic [95:0] DEF_SLV_LO = {TC1_LO, TC0_LO, DM_LO};
    localparam logic [95:0] DEF_SLV_HI = {TC1_HI, TC0_HI, DM_HI};

    function automatic int unsigned tmo_width(input int unsigned timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/bridge_decode.sv
// Combinational address decoder: one-hot slot hit against inclusive windows,
// lowest index wins on overlap, plus a miss flag.
module bridge_decode
    import bridge_pkg::*;
#(
    parameter int unsigned          NSLV   = 3,
    parameter int unsigned          AW     = 32,
    parameter logic [NSLV*AW-1:0]   SLV_LO = DEF_SLV_LO,
    parameter logic [NSLV*AW-1:0]   SLV_HI = DEF_SLV_HI
) (
    input  logic [AW-1:0]   addr,
    output logic [NSLV-1:0] hit,
    output logic            miss
);

    // Scan from the top so a lower-index hit overwrites any higher one.
    always_comb begin
        hit = '0;
        for (int i = NSLV - 1; i >= 0; i--) begin
            if ((addr >= SLV_LO[i*AW +: AW]) && (addr <= SLV_HI[i*AW +: AW])) begin
                hit    = '0;
                hit[i] = 1'b1;
            end
        end
        miss = ~|hit;
    end

endmodule

// File: rtl/sys_bridge_n.sv
// Registered CPU-to-NSLV slave bridge with one outstanding access and ack timeout.
// Optional error reporting (cpu_err, err_addr) is enabled by defining BRIDGE_ERR_EN.
module sys_bridge_n
    import bridge_pkg::*;
#(
    parameter int unsigned          NSLV    = 3,
    parameter int unsigned          AW      = 32,
    parameter int unsigned          DW      = 32,
    parameter logic [NSLV*AW-1:0]   SLV_LO  = DEF_SLV_LO,
    parameter logic [NSLV*AW-1:0]   SLV_HI  = DEF_SLV_HI,
    parameter int unsigned          TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cpu_req,
    input  logic [AW-1:0]        cpu_addr,
    input  logic [DW-1:0]        cpu_wdata,
    input  logic [DW/8-1:0]      cpu_byteen,
    output logic                 cpu_ready,
    output logic                 cpu_done,
    output logic [DW-1:0]        cpu_rdata,
    output logic                 cpu_err,
`ifdef BRIDGE_ERR_EN
    output logic [AW-1:0]        err_addr,
`endif
    output logic [NSLV-1:0]      slv_sel,
    output logic [AW-1:0]        slv_addr,
    output logic [DW-1:0]        slv_wdata,
    output logic [DW/8-1:0]      slv_byteen,
    output logic                 slv_wen,
    input  logic [NSLV-1:0]      slv_ack,
    input  logic [NSLV*DW-1:0]   slv_rdata
);

    localparam int unsigned BW = DW / 8;
    localparam int unsigned CW = tmo_width(TIMEOUT);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ready_d, done_d, wen_d;
    logic [DW-1:0]   rdata_d, wdata_d, sel_rdata;
    logic [NSLV-1:0] sel_d, dec_hit;
    logic [AW-1:0]   addr_d;
    logic [BW-1:0]   byteen_d;
    logic            dec_miss, ack_hit, tmo_hit;
`ifdef BRIDGE_ERR_EN
    logic            err_d;
    logic [AW-1:0]   err_addr_d;
`endif

    bridge_decode #(
        .NSLV   (NSLV),
        .AW     (AW),
        .SLV_LO (SLV_LO),
        .SLV_HI (SLV_HI)
    ) u_decode (
        .addr (cpu_addr),
        .hit  (dec_hit),
        .miss (dec_miss)
    );

    // Read data of the currently selected slot (slv_sel is one-hot or zero).
    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (slv_sel[i]) begin
                sel_rdata = sel_rdata | slv_rdata[i*DW +: DW];
            end
        end
    end

    assign ack_hit = |(slv_ack & slv_sel);
    assign tmo_hit = (cnt_q == CW'(TIMEOUT));

    // Next state and next value of every registered output.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        rdata_d  = cpu_rdata;
        sel_d    = slv_sel;
        addr_d   = slv_addr;
        wdata_d  = slv_wdata;
        byteen_d = slv_byteen;
        wen_d    = slv_wen;
`ifdef BRIDGE_ERR_EN
        err_d      = cpu_err;
        err_addr_d = err_addr;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cpu_req) begin
                    addr_d   = cpu_addr;
                    wdata_d  = cpu_wdata;
                    byteen_d = cpu_byteen;
                    wen_d    = |cpu_byteen;
                    if (dec_miss) begin
                        state_d = ST_RESP;
                        done_d  = 1'b1;
                        rdata_d = '0;
                        sel_d   = '0;
`ifdef BRIDGE_ERR_EN
                        err_d      = 1'b1;
                        err_addr_d = cpu_addr;
`endif
                    end else begin
                        state_d = ST_BUSY;
                        sel_d   = dec_hit;
                        cnt_d   = '0;
                    end
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q + CW'(1);
                if (ack_hit) begin
                    state_d = ST_RESP;
                    done_d  = 1'b1;
                    rdata_d = slv_wen ? '0 : sel_rdata;
                    sel_d   = '0;
`ifdef BRIDGE_ERR_EN
                    err_d = 1'b0;
`endif
                end else if (tmo_hit) begin
                    state_d = ST_RESP;
                    done_d  = 1'b1;
                    rdata_d = '0;
                    sel_d   = '0;
`ifdef BRIDGE_ERR_EN
                    err_d      = 1'b1;
                    err_addr_d = slv_addr;
`endif
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                sel_d   = '0;
            end
        endcase
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            cpu_ready  <= 1'b1;
            cpu_done   <= 1'b0;
            cpu_rdata  <= '0;
            slv_sel    <= '0;
            slv_addr   <= '0;
            slv_wdata  <= '0;
            slv_byteen <= '0;
            slv_wen    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cpu_ready  <= ready_d;
            cpu_done   <= done_d;
            cpu_rdata  <= rdata_d;
            slv_sel    <= sel_d;
            slv_addr   <= addr_d;
            slv_wdata  <= wdata_d;
            slv_byteen <= byteen_d;
            slv_wen    <= wen_d;
        end
    end

`ifdef BRIDGE_ERR_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            cpu_err  <= 1'b0;
            err_addr <= '0;
        end else begin
            cpu_err  <= err_d;
            err_addr <= err_addr_d;
        end
    end
`else
    assign cpu_err = 1'b0;
`endif

endmodule

// File: doc/sys_bridge_n.md
# sys_bridge_n

Parametrised, registered system bridge between the CPU data port and NSLV memory-mapped slaves (DM, timers, future peripherals). Decodes each CPU access against per-slot inclusive address windows, performs one outstanding transaction at a time with a slave-ready handshake, and returns a registered response. Unmapped accesses and slave timeouts produce a defined response instead of the silent zero of the previous bridge.

## Interface
- `NSLV`, 3: number of slave slots.
- `AW`, 32: address width.
- `DW`, 32: data width. `DW/8` byte enables.
- `SLV_LO`, {32'h7F10, 32'h7F00, 32'h0000}: packed NSLV×AW inclusive window lows. Slot i is `[i*AW +: AW]`.
- `SLV_HI`, {32'h7F1B, 32'h7F0B, 32'h2FFF}: packed inclusive window highs.
- `TIMEOUT`, 255: maximum cycles to wait for `slv_ack`, ≥1.

Ports:
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: synchronous, active-low reset.
- `cpu_req` input 1: access request.
- `cpu_addr` input AW: byte address.
- `cpu_wdata` input DW: write data.
- `cpu_byteen` input DW/8: write byte enables. All zero means read.
- `cpu_ready` output 1: bridge accepts a request this cycle.
- `cpu_done` output 1: one-cycle response strobe.
- `cpu_rdata` output DW: registered read data, valid with `cpu_done`.
- `cpu_err` output 1: error response, valid with `cpu_done`.
- `slv_sel` output NSLV: one-hot slave select.
- `slv_addr` output AW: latched address.
- `slv_wdata` output DW: latched write data.
- `slv_byteen` output DW/8: latched byte enables.
- `slv_wen` output 1: latched `|byteen`.
- `slv_ack` input NSLV: per-slave completion.
- `slv_rdata` input NSLV×DW: packed per-slave read data.

## Operation
- FSM has three states: IDLE, BUSY and RESP.
- **IDLE**: `cpu_ready`=1. On `cpu_req`, latch addr, wdata and byteen, and decode the address.
  - Hit: go to BUSY with `slv_sel` one-hot.
  - No hit: go to RESP with rdata=0 and err=1 (see Configuration).
- **Decode**: a slot hits when `SLV_LO[i] ≤ addr ≤ SLV_HI[i]`. If windows overlap, the lowest index wins.
- **BUSY**: hold all `slv_*` outputs stable. The timeout counter increments each cycle.
  - If `slv_ack[sel]` is set, capture `slv_rdata[sel]` (write: 0), set err=0, and go to RESP.
  - If the counter equals TIMEOUT with no ack, set rdata=0 and err=1, then go to RESP.
  - Acks from unselected slots are ignored.
- **RESP**: `cpu_done`=1 for exactly one cycle, `slv_sel`=0, then go to IDLE.
- `cpu_req` while not in IDLE is ignored. The CPU must hold the request until `cpu_ready`.
- The timeout counter is `$clog2(TIMEOUT+1)` bits wide and clears on entry to BUSY.
- **Reset** (`reset`=0 at a clock edge):
  - State returns to IDLE.
  - `cpu_done`, `cpu_err` and `slv_sel` reset to 0; `cpu_rdata` resets to 0.
  - `slv_addr`, `slv_wdata`, `slv_byteen` and `slv_wen` reset to 0.
  - An in-flight transaction is abandoned with no response.

## Timing
- Request accepted at edge 0 → `slv_sel` asserted in cycle 1.
- An ack in cycle 1 → `cpu_done` in cycle 2. Minimum latency is 2 cycles; +1 per wait cycle.
- An unmapped access gives `cpu_done` in cycle 1.
- A timeout gives `cpu_done` TIMEOUT+1 cycles after `slv_sel` rises.
- `cpu_ready` is 0 from the cycle after acceptance through RESP. A new request is accepted at the earliest in the cycle after `cpu_done`.
- All outputs are registered, with no combinational path from CPU inputs to outputs.

## Configuration
- The macro is `BRIDGE_ERR_EN`.
- Defined:
  - Unmapped accesses and timeouts assert `cpu_err`.
  - An extra output `err_addr` (AW) latches the faulting address; it resets to 0 and is sticky until the next error.
- Undefined:
  - `cpu_err` is tied 0, `err_addr` is absent, and unmapped writes are dropped.
  - Unmapped and timed-out reads still return 0 with `cpu_done`.

## Structure
- `bridge_pkg` holds:
  - the FSM state encoding (IDLE=2'd0, BUSY=2'd1, RESP=2'd2);
  - default DM/TC0/TC1 window constants;
  - the timeout-width function.
- Sub-module `bridge_decode` is purely combinational. It takes addr, SLV_LO and SLV_HI and produces a one-hot hit vector plus a `miss` flag.

## Test plan
- Read `0x0000_0010`, DM acks in cycle 1 with `0xDEAD_BEEF` → `cpu_done` in cycle 2, rdata=`0xDEAD_BEEF`, err=0.
- Write `0x7F04`, byteen=4'hF, TC0 acks after 3 wait cycles → `slv_sel`=3'b010 and `slv_wen`=1 held stable throughout; `cpu_done` in cycle 5.
- Read `0x5000` (unmapped) → `cpu_done` in cycle 1, rdata=0; with `BRIDGE_ERR_EN`, err=1 and err_addr=`0x5000`.
- TIMEOUT=4, read `0x7F10`, TC1 never acks → `cpu_done` exactly 5 cycles after `slv_sel` rises, err=1 (with macro), rdata=0.
- `reset`=0 during BUSY → next cycle IDLE, `slv_sel`=0, `cpu_ready`=1, and no `cpu_done`.
- Back-to-back requests with `cpu_req` held high → second access accepted only in the cycle after the first `cpu_done`; stray `slv_ack[0]` during a TC1 access is ignored.
